// File: rtl/mem_access_unit.sv
// Memory stage of the 5-stage pipeline: word loads/stores on an internal RAM with LATENCY-cycle occupancy.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned mem ops retire without RAM write or reg_wr and set align_err.
module mem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        turn_off,
  input  logic [31:0] alu_out,
  input  logic [31:0] bus_b_buff,
  input  logic [3:0]  rd_buf3,
  input  logic [7:0]  cu_flags3,
  output logic [31:0] mem_out,
  output logic [3:0]  rd_buf4,
  output logic [7:0]  cu_flags4,
  output logic        reg_wr3,
  output logic        mem_busy,
  output logic [31:0] out,
  output logic        align_err
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [31:0]       ram_q [2**ADDR_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mem_out_q, mem_out_d;
  logic [3:0]        rd_buf4_q, rd_buf4_d;
  logic [7:0]        cu_flags4_q, cu_flags4_d;
  logic              reg_wr3_q, reg_wr3_d;
  logic [31:0]       out_q, out_d;
  logic              align_err_q, align_err_d;

  logic              mem_rd_s, mem_op_s, store_s, misalign_s, busy_s, ram_we_s;
  logic [ADDR_W-1:0] addr_s;

  assign mem_rd_s = cu_flags3[0];
  assign mem_op_s = cu_flags3[0] | cu_flags3[1];
  assign store_s  = cu_flags3[1] & ~cu_flags3[0];
  assign addr_s   = alu_out[ADDR_W+1:2];
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = |alu_out[1:0];
`else
  assign misalign_s = 1'b0;
`endif
  // Stall depends only on the op flags, freeze and the occupancy counter.
  assign busy_s   = mem_op_s & ~turn_off & (cnt_q < CNT_LAST);
  assign ram_we_s = mem_op_s & ~turn_off & ~busy_s & store_s & ~misalign_s;

  // Next-state: freeze holds, busy inserts a bubble, retire/pass-through load the outputs.
  always_comb begin
    cnt_d       = cnt_q;
    mem_out_d   = mem_out_q;
    rd_buf4_d   = rd_buf4_q;
    cu_flags4_d = cu_flags4_q;
    reg_wr3_d   = reg_wr3_q;
    out_d       = out_q;
    align_err_d = align_err_q;
    if (turn_off) begin
      cnt_d = cnt_q;
    end else if (busy_s) begin
      cnt_d       = cnt_q + CNT_W'(1);
      mem_out_d   = 32'd0;
      rd_buf4_d   = 4'd0;
      cu_flags4_d = 8'd0;
      reg_wr3_d   = 1'b0;
    end else begin
      cnt_d       = {CNT_W{1'b0}};
      rd_buf4_d   = rd_buf3;
      cu_flags4_d = cu_flags3;
      reg_wr3_d   = cu_flags3[2];
      mem_out_d   = alu_out;
      if (mem_op_s && misalign_s) begin
        mem_out_d      = 32'd0;
        cu_flags4_d[2] = 1'b0;
        reg_wr3_d      = 1'b0;
        align_err_d    = 1'b1;
      end else if (mem_op_s && mem_rd_s) begin
        mem_out_d = ram_q[addr_s];
      end else if (store_s) begin
        out_d = bus_b_buff;
      end else begin
        mem_out_d = alu_out;
      end
    end
  end

  // Pipeline output and counter registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q       <= {CNT_W{1'b0}};
      mem_out_q   <= 32'd0;
      rd_buf4_q   <= 4'd0;
      cu_flags4_q <= 8'd0;
      reg_wr3_q   <= 1'b0;
      out_q       <= 32'd0;
      align_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_out_q   <= mem_out_d;
      rd_buf4_q   <= rd_buf4_d;
      cu_flags4_q <= cu_flags4_d;
      reg_wr3_q   <= reg_wr3_d;
      out_q       <= out_d;
      align_err_q <= align_err_d;
    end
  end

  // Data RAM: contents survive reset; written only on a store retire.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[addr_s] <= bus_b_buff;
    end
  end

  assign mem_out   = mem_out_q;
  assign rd_buf4   = rd_buf4_q;
  assign cu_flags4 = cu_flags4_q;
  assign reg_wr3   = reg_wr3_q;
  assign mem_busy  = busy_s;
  assign out       = out_q;
  assign align_err = align_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the 5-stage pipelined CPU: sits between the execute stage and write-back, consuming the execute stage's ALU result, store data, destination register and control flags. It performs word loads and stores on an internal data RAM with a configurable multi-cycle access latency. While an access is in progress it raises a stall request, and it inserts bubbles downstream until the access retires. Non-memory instructions pass straight through with one register stage.

## Interface
Parameters:
- ADDR_W, 8, word-address width; the RAM holds 2^ADDR_W 32-bit words
- LATENCY, 2, cycles a memory op occupies the stage (≥1)

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  asynchronous, active-low reset
- turn_off  in  1  pipeline freeze; all state holds, no RAM write
- alu_out  in  32  address (memory ops) or result (ALU ops)
- bus_b_buff  in  32  store data
- rd_buf3  in  4  destination register
- cu_flags3  in  8  control flags: [0] mem_rd, [1] mem_wr, [2] reg_wr, [7:3] passed through unchanged
- mem_out  out  32  registered result to write-back
- rd_buf4  out  4  registered destination register
- cu_flags4  out  8  registered flags
- reg_wr3  out  1  registered cu_flags4[2], used for forwarding
- mem_busy  out  1  combinational stall request to upstream stages
- out  out  32  last value written to RAM (debug)
- align_err  out  1  sticky misalignment flag (see Configuration)

## Operation
- mem_op = cu_flags3[0] | cu_flags3[1]. If both bits are set, the op is treated as a load; mem_wr is ignored.
- Word address = alu_out[ADDR_W+1:2]. Upper address bits are ignored and the address wraps.
- Cycle counter cnt (width clog2(LATENCY)+1) counts the cycles the current mem op has been held at the input.
- mem_busy = mem_op & ~turn_off & (cnt < LATENCY-1). With LATENCY=1, mem_busy is never asserted.
- While mem_busy is high:
  - cnt increments.
  - Output registers load a bubble: cu_flags4=0, reg_wr3=0, rd_buf4=0, mem_out=0.
  - The RAM is not written.
- Retire cycle (mem_op & ~mem_busy & ~turn_off), at the clock edge:
  - cnt clears to 0.
  - Store: RAM[addr] ← bus_b_buff, and out ← bus_b_buff.
  - Load: mem_out ← RAM[addr].
  - rd_buf4, cu_flags4 and reg_wr3 load their inputs.
- Non-mem op: mem_out ← alu_out, other outputs load their inputs, cnt stays 0.
- Load data reflects all stores retired on earlier edges. There is no store-to-load bypass within a cycle, and none is needed because accesses serialise.
- turn_off=1: cnt, the output registers, out, align_err and the RAM all hold.

## Timing
- Reset (clear=0, asynchronous): mem_out=0, rd_buf4=0, cu_flags4=0, reg_wr3=0, out=0, align_err=0, cnt=0. RAM contents are not reset.
- Releasing reset mid-access abandons the access: no write occurs and cnt restarts at 0.
- Non-mem latency: 1 cycle, input to registered output.
- Mem-op latency: LATENCY cycles. Upstream holds its inputs stable for the LATENCY-1 cycles that mem_busy is high.
- Back-to-back mem ops: each takes LATENCY cycles. cnt is 0 at the start of each op.
- mem_busy depends combinationally on cu_flags3, turn_off and cnt only. It does not depend on the RAM.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A mem op with alu_out[1:0]≠0 still takes LATENCY cycles, but suppresses the RAM write and the reg_wr flag.
  - In that case mem_out=0 on retire, and align_err sets and stays set until reset.
- MEM_ALIGN_CHECK_EN undefined:
  - alu_out[1:0] is ignored and the access proceeds at the word address.
  - align_err is tied to 0.

## Test plan
- Reset mid-access: LATENCY=2, store presented, drive clear=0 during the busy cycle → all outputs 0, mem_busy=0 after release, no RAM write; a later load of the same address returns the value previously stored there.
- ALU pass-through: cu_flags3=8'h04, alu_out=32'd77, rd_buf3=5 → next edge mem_out=77, rd_buf4=5, reg_wr3=1; mem_busy=0 throughout.
- Store then load: LATENCY=2, store alu_out=32'h10, bus_b_buff=32'hDEADBEEF.
  - mem_busy=1 for exactly one cycle and the output is a bubble.
  - out=DEADBEEF after retire.
  - A following load from 32'h10 with reg_wr gives mem_out=DEADBEEF after 2 cycles.
- Freeze: turn_off=1 for 3 cycles during a busy load → cnt and outputs unchanged, mem_busy=0. After release, the load completes in the remaining 1 cycle.
- Wrap: ADDR_W=8, store 32'h5 to alu_out=32'h400 → a load from 32'h0 returns 5.
- Misalignment with MEM_ALIGN_CHECK_EN: store to alu_out=32'h11 → no RAM write, align_err=1, reg_wr3=0. Without the macro, the data is written at word 4 and align_err=0.
